// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman encoder/decoder pair: table geometry,
// FSM state encoding and the code-table entry layout.
package huffman_pkg;
   localparam int SYM_N  = 6;
   localparam int CODE_W = 8;

   typedef enum logic {IDLE, RUN} state_e;

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic [CODE_W-1:0] mask;
   } entry_t;

   // Element k holds the entry for symbol k+1.
   typedef entry_t [SYM_N-1:0] table_t;
endpackage

// File: rtl/huffman_decoder_if.sv
// Table-load and bitstream bus between the encoder side and the decoder.
interface huffman_decoder_if;
   import huffman_pkg::*;

   logic              code_valid;
   logic [CODE_W-1:0] HC1, HC2, HC3, HC4, HC5, HC6;
   logic [CODE_W-1:0] M1, M2, M3, M4, M5, M6;
   logic              bit_valid;
   logic              bit_in;
   logic              table_ok;
   logic              gray_valid;
   logic [CODE_W-1:0] gray_data;
   logic              err;
   logic [CODE_W-1:0] sym_cnt;

   modport master (
      output code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
             M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
      input  table_ok, gray_valid, gray_data, err, sym_cnt
   );

   modport slave (
      input  code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
             M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
      output table_ok, gray_valid, gray_data, err, sym_cnt
   );
endinterface

// File: rtl/huff_match.sv
// Combinational 6-way codeword comparator; returns the 1-based symbol of the
// lowest-numbered entry whose length and masked bits match.
module huff_match
   import huffman_pkg::*;
(
   input  logic [CODE_W-1:0] nsh_i,
   input  logic [CODE_W-1:0] ncm_i,
   input  table_t            tbl_i,
   output logic              hit_o,
   output logic [2:0]        idx_o
);
   // Scan downward so the lowest matching entry is written last and wins.
   always_comb begin
      hit_o = 1'b0;
      idx_o = 3'd0;
      for (int k = SYM_N-1; k >= 0; k--) begin
         if (tbl_i[k].mask != '0 && tbl_i[k].mask == ncm_i &&
             (nsh_i & tbl_i[k].mask) == tbl_i[k].code) begin
            hit_o = 1'b1;
            idx_o = 3'(k + 1);
         end
      end
   end
endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: latches the code table, shifts in one bit per clock
// and emits a symbol pulse per completed codeword or an error after 8 bits.
module huffman_decoder
   import huffman_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   huffman_decoder_if.slave bus
);
   state_e            state_q, state_d;
   table_t            tbl_q, tbl_d, tbl_in;
   logic [CODE_W-1:0] sh_q, sh_d, cm_q, cm_d;
   logic [CODE_W-1:0] gd_q, gd_d, cnt_q, cnt_d;
   logic              table_ok_q, table_ok_d;
   logic              gv_q, gv_d, err_q, err_d;
   logic [CODE_W-1:0] nsh, ncm;
   logic              hit;
   logic [2:0]        idx;

   assign nsh = {sh_q[CODE_W-2:0], bus.bit_in};
   assign ncm = {cm_q[CODE_W-2:0], 1'b1};

   always_comb begin
      tbl_in[0] = '{code: bus.HC1, mask: bus.M1};
      tbl_in[1] = '{code: bus.HC2, mask: bus.M2};
      tbl_in[2] = '{code: bus.HC3, mask: bus.M3};
      tbl_in[3] = '{code: bus.HC4, mask: bus.M4};
      tbl_in[4] = '{code: bus.HC5, mask: bus.M5};
      tbl_in[5] = '{code: bus.HC6, mask: bus.M6};
   end

   huff_match u_match (
      .nsh_i (nsh),
      .ncm_i (ncm),
      .tbl_i (tbl_q),
      .hit_o (hit),
      .idx_o (idx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.code_valid) state_d = RUN;
   end

   // A table load takes priority over a coincident bit, which is dropped.
   always_comb begin
      tbl_d      = tbl_q;
      sh_d       = sh_q;
      cm_d       = cm_q;
      table_ok_d = table_ok_q;
      gd_d       = gd_q;
      cnt_d      = cnt_q;
      gv_d       = 1'b0;
      err_d      = 1'b0;
      if (bus.code_valid) begin
         tbl_d      = tbl_in;
         sh_d       = '0;
         cm_d       = '0;
         table_ok_d = 1'b1;
      end else if (state_q == RUN && bus.bit_valid) begin
         if (hit) begin
            gd_d  = CODE_W'(idx);
            gv_d  = 1'b1;
            cnt_d = cnt_q + 8'd1;
            sh_d  = '0;
            cm_d  = '0;
         end else if (ncm == 8'hFF) begin
            err_d = 1'b1;
            sh_d  = '0;
            cm_d  = '0;
         end else begin
            sh_d = nsh;
            cm_d = ncm;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tbl_q      <= '0;
         sh_q       <= '0;
         cm_q       <= '0;
         table_ok_q <= 1'b0;
         gd_q       <= '0;
         cnt_q      <= '0;
         gv_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         tbl_q      <= tbl_d;
         sh_q       <= sh_d;
         cm_q       <= cm_d;
         table_ok_q <= table_ok_d;
         gd_q       <= gd_d;
         cnt_q      <= cnt_d;
         gv_q       <= gv_d;
         err_q      <= err_d;
      end
   end

   assign bus.table_ok   = table_ok_q;
   assign bus.gray_valid = gv_q;
   assign bus.gray_data  = gd_q;
   assign bus.err        = err_q;
   assign bus.sym_cnt    = cnt_q;
endmodule

// File: tb/tb_huffman_decoder.sv
// Directed and randomized bench for huffman_decoder against a codeword-level
// reference model that tracks accumulated bits as a value and a length.
module tb_huffman_decoder;
   import huffman_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   huffman_decoder_if bus ();
   huffman_decoder dut (.clk(clk), .reset(reset), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] thc [6];
   logic [7:0] tm  [6];
   assign bus.HC1 = thc[0]; assign bus.M1 = tm[0];
   assign bus.HC2 = thc[1]; assign bus.M2 = tm[1];
   assign bus.HC3 = thc[2]; assign bus.M3 = tm[2];
   assign bus.HC4 = thc[3]; assign bus.M4 = tm[3];
   assign bus.HC5 = thc[4]; assign bus.M5 = tm[4];
   assign bus.HC6 = thc[5]; assign bus.M6 = tm[5];

   // Reference model: codeword lengths, accumulated value/length, outputs.
   bit         mok;
   int         mcode [6];
   int         mlk   [6];
   int         mval, mlen, mcnt;
   bit         mgv, merr;
   logic [7:0] mgd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int len_of(input logic [7:0] m);
      for (int l = 1; l <= 8; l++)
         if (int'(m) == (1 << l) - 1) return l;
      return -1;
   endfunction

   task automatic set_T();
      thc[0] = 8'h01; tm[0] = 8'h01;
      thc[1] = 8'h01; tm[1] = 8'h03;
      thc[2] = 8'h00; tm[2] = 8'h07;
      thc[3] = 8'h03; tm[3] = 8'h0F;
      thc[4] = 8'h05; tm[4] = 8'h1F;
      thc[5] = 8'h04; tm[5] = 8'h1F;
   endtask

   task automatic model_reset();
      mok = 0; mval = 0; mlen = 0; mcnt = 0; mgv = 0; merr = 0; mgd = 8'h00;
      for (int k = 0; k < 6; k++) begin mcode[k] = 0; mlk[k] = -1; end
   endtask

   task automatic model_edge(input bit cv, input bit bv, input bit b);
      int hitk;
      mgv = 0; merr = 0;
      if (cv) begin
         mok = 1; mval = 0; mlen = 0;
         for (int k = 0; k < 6; k++) begin
            mcode[k] = int'(thc[k]);
            mlk[k]   = len_of(tm[k]);
         end
      end else if (mok && bv) begin
         mval = mval * 2 + int'(b);
         mlen++;
         hitk = -1;
         for (int k = 0; k < 6; k++)
            if (hitk < 0 && mlk[k] == mlen && mcode[k] == mval) hitk = k;
         if (hitk >= 0) begin
            mgd = 8'(hitk + 1); mgv = 1; mcnt = (mcnt + 1) % 256;
            mval = 0; mlen = 0;
         end else if (mlen == 8) begin
            merr = 1; mval = 0; mlen = 0;
         end
      end
   endtask

   task automatic check_outs(input string tag);
      chk({tag, ".gray_valid"}, 32'(bus.gray_valid), 32'(mgv));
      chk({tag, ".gray_data"},  32'(bus.gray_data),  32'(mgd));
      chk({tag, ".err"},        32'(bus.err),        32'(merr));
      chk({tag, ".sym_cnt"},    32'(bus.sym_cnt),    32'(mcnt));
      chk({tag, ".table_ok"},   32'(bus.table_ok),   32'(mok));
   endtask

   task automatic step(input bit cv, input bit bv, input bit b, input string tag);
      @(negedge clk);
      bus.code_valid = cv; bus.bit_valid = bv; bus.bit_in = b;
      @(posedge clk);
      model_edge(cv, bv, b);
      #1;
      check_outs(tag);
   endtask

   task automatic send(input string bits, input string tag);
      for (int i = 0; i < bits.len(); i++)
         step(1'b0, 1'b1, bits[i] == "1", tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk({tag, ".gray_valid"}, 32'(bus.gray_valid), 32'd0);
      chk({tag, ".gray_data"},  32'(bus.gray_data),  32'd0);
      chk({tag, ".err"},        32'(bus.err),        32'd0);
      chk({tag, ".sym_cnt"},    32'(bus.sym_cnt),    32'd0);
      chk({tag, ".table_ok"},   32'(bus.table_ok),   32'd0);
      chk({tag, ".state"},      32'(dut.state_q),    32'(IDLE));
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.code_valid = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
      for (int k = 0; k < 6; k++) begin thc[k] = 8'h00; tm[k] = 8'h00; end
      model_reset();
      #12;
      reset = 1'b0;
      check_outs("reset");

      // Bits before any table load are ignored.
      set_T();
      send("1011000", "t2.noload");
      step(1'b1, 1'b0, 1'b0, "t2.load");
      step(1'b1, 1'b0, 1'b0, "t2.reload");

      // All six codewords back to back.
      send("10100000110010100100", "t1.stream");
      chk("t1.sym_cnt", 32'(bus.sym_cnt), 32'd6);
      chk("t1.last_sym", 32'(bus.gray_data), 32'd6);

      // Entry 6 disabled: 00100 then 000 runs to 8 bits without a match.
      tm[5] = 8'h00;
      step(1'b1, 1'b0, 1'b0, "t3.load");
      send("0010000", "t3.pre");
      send("0", "t3.err");
      chk("t3.err_pulse", 32'(bus.err), 32'd1);
      send("01", "t3.after");
      chk("t3.after_sym", 32'(bus.gray_data), 32'd2);

      // Load coincident with a bit discards the partial code and the bit.
      set_T();
      step(1'b1, 1'b0, 1'b0, "t4.load");
      send("00", "t4.partial");
      step(1'b1, 1'b1, 1'b0, "t4.load_bit");
      send("1", "t4.final");
      chk("t4.sym", 32'(bus.gray_data), 32'd1);
      chk("t4.gv", 32'(bus.gray_valid), 32'd1);

      // 256 single-bit codes: continuous valid, counter wraps.
      do_reset("t5.rst");
      step(1'b1, 1'b0, 1'b0, "t5.load");
      for (int i = 0; i < 256; i++) send("1", "t5.ones");
      chk("t5.wrap", 32'(bus.sym_cnt), 32'd0);

      // Reset in the middle of 00101.
      send("001", "t6.partial");
      do_reset("t6.rst");
      send("00101", "t6.idle");
      step(1'b1, 1'b0, 1'b0, "t6.load");
      send("00101", "t6.decode");
      chk("t6.sym", 32'(bus.gray_data), 32'd5);

      // Random bitstreams with occasional random or standard table loads.
      for (int i = 0; i < 800; i++) begin
         int r;
         r = int'($urandom_range(99));
         if (r < 3) begin
            for (int k = 0; k < 6; k++) begin
               int l, r2;
               l  = int'($urandom_range(1, 8));
               r2 = int'($urandom_range(99));
               thc[k] = 8'($urandom) & 8'((1 << l) - 1);
               tm[k]  = (r2 < 10) ? 8'h00 : (r2 < 20) ? 8'($urandom) : 8'((1 << l) - 1);
            end
            step(1'b1, 1'($urandom), 1'($urandom), "rnd.load");
         end else if (r < 6) begin
            set_T();
            step(1'b1, 1'($urandom), 1'($urandom), "rnd.loadT");
         end else begin
            step(1'b0, r >= 15, 1'($urandom), "rnd.bit");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Serial Huffman decoder, the receive-side counterpart of the `huffman` encoder block. It latches the six-entry code table (HC1..HC6 codes, M1..M6 masks) when the encoder raises `code_valid`, then consumes a code bitstream one bit per clock, MSB of each code first. It emits one gray symbol (1..6) per completed codeword and flags bit sequences that match no codeword.

## Interface
- No parameters. Widths are fixed: 8-bit codes, masks and symbols, 6 table entries.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `code_valid`  in  1  table-load strobe; table is sampled on every cycle it is high.
- `HC1`..`HC6`  in  8 each  right-aligned codeword for symbols 1..6.
- `M1`..`M6`  in  8 each  right-aligned mask of 2^L−1 for code length L; 0 disables the entry.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `bit_in`  in  1  next code bit, MSB of each codeword first.
- `table_ok`  out  1  a table has been loaded since reset.
- `gray_valid`  out  1  one-cycle pulse: `gray_data` holds a decoded symbol.
- `gray_data`  out  8  decoded symbol, 1..6; holds its last value between pulses.
- `err`  out  1  one-cycle pulse: 8 bits accumulated without any match.
- `sym_cnt`  out  8  count of decoded symbols; wraps 255→0.

## Operation
- Reset values: `table_ok`=0, `gray_valid`=0, `gray_data`=0, `err`=0, `sym_cnt`=0. Internal state is also cleared: table registers, shift register `sh`=0, length mask `cm`=0.
- FSM states:
  - IDLE: no table. Bits are ignored. `code_valid` moves to RUN.
  - RUN: decoding. `code_valid` reloads the table, clears `sh`/`cm` (any partial codeword is discarded) and stays in RUN.
- Bit accept happens in RUN when `bit_valid` is high and `code_valid` is low:
  - `nsh = {sh[6:0], bit_in}`
  - `ncm = {cm[6:0], 1'b1}`
- Match for entry k: `Mk != 0`, `Mk == ncm`, and `(nsh & Mk) == HCk`. A prefix-free table gives at most one match. If several match, the lowest k wins.
- On a match:
  - `gray_data` ← k.
  - `gray_valid` pulses.
  - `sym_cnt` increments.
  - `sh`, `cm` ← 0.
- No match and `ncm == 8'hFF`: `err` pulses, `sh`, `cm` ← 0.
- No match otherwise: `sh` ← `nsh`, `cm` ← `ncm`.
- `code_valid` together with `bit_valid` in the same cycle: the table load wins and the bit is dropped.
- Mask inputs are not validated. Non-2^L−1 masks simply never match.

## Timing
- Throughput: one bit per clock, back-to-back, with no stall output.
- Latency: a bit accepted at edge t that completes a codeword produces `gray_valid`/`gray_data` valid from edge t+1 for exactly one cycle. `err` has the same timing.
- A new codeword may start on the bit immediately after a completing bit. Consecutive 1-bit codes yield `gray_valid` high on consecutive cycles.
- The table is in effect for the bit in the cycle after `code_valid` is sampled.
- Asserting `reset` mid-codeword: all outputs clear immediately (asynchronously), and the state returns to IDLE. A table must be reloaded after reset.

## Structure
- Shared package `huffman_pkg` holds:
  - `SYM_N=6`, `CODE_W=8`
  - FSM state enum {IDLE, RUN}
  - a table-entry struct {code, mask}
  
  The encoder uses the same package.
- One natural sub-module, `huff_match`: combinational 6-way comparator taking `nsh`, `ncm` and the table, returning a hit flag and the 3-bit index. Everything else (table registers, shift register, FSM, counter) lives in the top block.

## Test plan
Table T used below: HC/M = 01/01, 01/03, 00/07, 03/0F, 05/1F, 04/1F, i.e. codes 1, 01, 000, 0011, 00101, 00100.

1. Load T, then send 1,01,000,0011,00101,00100 back-to-back (20 bits).
   - Required: `gray_data` 1,2,3,4,5,6, each `gray_valid` pulse one cycle after the codeword's last bit.
   - Required: `sym_cnt`=6, `err` never asserted.
2. Send bits before any `code_valid`.
   - Required: no outputs change. `table_ok` rises only on the first load.
3. Load T with M6=0, then send 00100 followed by 000.
   - Required: `err` pulses one cycle after the 8th bit.
   - Required: no symbol is emitted, and the next codeword decodes correctly afterwards.
4. Send 00 of 0011, then assert `code_valid` with T together with `bit_valid`, then send 1.
   - Required: the partial codeword is discarded and the dropped bit is ignored.
   - Required: `gray_data`=1 one cycle after the final 1.
5. Send 256 consecutive 1-bit codes.
   - Required: `gray_valid` is high on every cycle, and `sym_cnt` wraps to 0.
6. Assert `reset` after 3 bits of 00101.
   - Required: all outputs return to 0 and the state is IDLE.
   - Required: after reload, 00101 decodes to 5.
